// File: rtl/game_sequencer_pkg.sv
// rtl/game_sequencer_pkg.sv - shared state/direction codes and widths for the snake sequencer
package game_sequencer_pkg;

  localparam int TAIL_SIZE = 7;
  localparam int PERIOD_W  = 32;
  localparam int SEC_W     = 32;
  localparam int TIME_W    = 7;

  typedef enum logic [2:0] {
    STATE_IDLE   = 3'd0,
    STATE_INGAME = 3'd1,
    STATE_PAUSE  = 3'd2,
    STATE_OVER   = 3'd3,
    STATE_WON    = 3'd4,
    STATE_TEST   = 3'd5
  } game_state_t;

  localparam logic [1:0] DIR_LEFT  = 2'd0;
  localparam logic [1:0] DIR_TOP   = 2'd1;
  localparam logic [1:0] DIR_RIGHT = 2'd2;
  localparam logic [1:0] DIR_DOWN  = 2'd3;

  // LEFT<->RIGHT and TOP<->DOWN differ only in the upper code bit
  function automatic logic [1:0] opposite_dir(input logic [1:0] dir);
    return dir ^ 2'b10;
  endfunction

endpackage

// File: rtl/game_tick_div.sv
// rtl/game_tick_div.sv - enable/clear controlled period counter with single-cycle strobe
module game_tick_div #(
  parameter int W = 32
) (
  input  logic         vga_clk,
  input  logic         reset_p,
  input  logic         enable,
  input  logic         clear,
  input  logic [W-1:0] period,
  output logic         tick
);

  logic [W-1:0] count;
  logic [W:0]   count_next;

  // compare count+1 against period so a shrinking period never underflows
  assign count_next = {1'b0, count} + {{W{1'b0}}, 1'b1};
  assign tick       = enable && (count_next >= {1'b0, period});

  always_ff @(posedge vga_clk or posedge reset_p) begin
    if (reset_p) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else if (enable) begin
      count <= count_next[W-1:0];
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - snake game FSM, movement tick, direction filter and round timer
// Optional TEST_MODE_EN: start edge with pause held in IDLE enters a free-running test state.
module game_sequencer
  import game_sequencer_pkg::*;
#(
  parameter int TICK_BASE    = 2_500_000,
  parameter int TICK_STEP    = 62_500,
  parameter int TICK_MIN     = 625_000,
  parameter int SEC_DIV      = 25_000_000,
  parameter int TIME_LIMIT_S = 120,
  parameter int TAIL_W       = TAIL_SIZE
) (
  input  logic              vga_clk,
  input  logic              reset_p,
  input  logic              btn_start,
  input  logic              btn_pause,
  input  logic              dir_req_valid,
  input  logic [1:0]        dir_req,
  input  logic              game_over_in,
  input  logic              game_won_in,
  input  logic [TAIL_W-1:0] tail_count,
  output logic [2:0]        game_state,
  output logic [1:0]        direction,
  output logic              update_tick,
  output logic              logic_reset,
  output logic [TIME_W-1:0] time_left,
  output logic              flag_time_max
);

  localparam int                 SW        = PERIOD_W + TAIL_W;
  localparam logic [SW-1:0]      SPAN      = SW'(TICK_BASE - TICK_MIN);
  localparam logic [SEC_W-1:0]   SEC_LAST  = SEC_W'(SEC_DIV - 1);
  localparam logic [TIME_W-1:0]  TIME_FULL = TIME_W'(TIME_LIMIT_S);

  game_state_t         state, next_state;
  logic                btn_start_q, btn_pause_q;
  logic                start_edge, pause_edge;
  logic                restart, run, tick_en, tick_clear;
  logic [1:0]          pending;
  logic [SEC_W-1:0]    sec_cnt;
  logic [SW-1:0]       step_total;
  logic [PERIOD_W-1:0] game_period, div_period;

  assign start_edge = btn_start & ~btn_start_q;
  assign pause_edge = btn_pause & ~btn_pause_q;

  // full-width product; anything beyond the span saturates to the floor
  assign step_total  = SW'(tail_count) * SW'(TICK_STEP);
  assign game_period = (step_total >= SPAN) ? PERIOD_W'(TICK_MIN)
                                            : PERIOD_W'(TICK_BASE) - step_total[PERIOD_W-1:0];
  assign div_period  = (state == STATE_TEST) ? PERIOD_W'(TICK_BASE) : game_period;

  always_comb begin
    next_state = state;
    restart    = 1'b0;
    case (state)
      STATE_IDLE: begin
        if (start_edge) begin
`ifdef TEST_MODE_EN
          if (btn_pause) begin
            next_state = STATE_TEST;
          end else begin
            restart    = 1'b1;
            next_state = STATE_INGAME;
          end
`else
          restart    = 1'b1;
          next_state = STATE_INGAME;
`endif
        end
      end
      STATE_INGAME: begin
        if (game_over_in)                      next_state = STATE_OVER;
        else if (game_won_in || flag_time_max) next_state = STATE_WON;
        else if (pause_edge)                   next_state = STATE_PAUSE;
      end
      STATE_PAUSE: begin
        if (pause_edge) next_state = STATE_INGAME;
      end
      STATE_OVER, STATE_WON: begin
        if (start_edge) begin
          restart    = 1'b1;
          next_state = STATE_INGAME;
        end
      end
      STATE_TEST: begin
        if (start_edge) next_state = STATE_IDLE;
      end
      default: next_state = STATE_IDLE;
    endcase
  end

  // counters only advance on cycles that stay in play, so a leaving cycle never ticks
  assign run        = (state == STATE_INGAME) && (next_state == STATE_INGAME);
  assign tick_en    = run || ((state == STATE_TEST) && (next_state == STATE_TEST));
  assign tick_clear = restart || (state == STATE_IDLE);

  game_tick_div #(.W(PERIOD_W)) u_tick_div (
    .vga_clk (vga_clk),
    .reset_p (reset_p),
    .enable  (tick_en),
    .clear   (tick_clear),
    .period  (div_period),
    .tick    (update_tick)
  );

  assign game_state  = state;
  assign logic_reset = restart;

  always_ff @(posedge vga_clk or posedge reset_p) begin
    if (reset_p) begin
      state         <= STATE_IDLE;
      btn_start_q   <= 1'b0;
      btn_pause_q   <= 1'b0;
      direction     <= DIR_RIGHT;
      pending       <= DIR_RIGHT;
      time_left     <= TIME_FULL;
      flag_time_max <= 1'b0;
      sec_cnt       <= '0;
    end else begin
      state       <= next_state;
      btn_start_q <= btn_start;
      btn_pause_q <= btn_pause;
      if (restart) begin
        direction     <= DIR_RIGHT;
        pending       <= DIR_RIGHT;
        time_left     <= TIME_FULL;
        flag_time_max <= 1'b0;
        sec_cnt       <= '0;
      end else if (run) begin
        if (dir_req_valid && (dir_req != opposite_dir(direction))) pending <= dir_req;
        if (update_tick) direction <= pending;
        if (sec_cnt == SEC_LAST) begin
          sec_cnt <= '0;
          if (time_left != '0) begin
            time_left <= time_left - 1'b1;
            if (time_left == TIME_W'(1)) flag_time_max <= 1'b1;
          end
        end else begin
          sec_cnt <= sec_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - table-driven and directed checks for game_sequencer
module tb_game_sequencer;

  logic       vga_clk = 1'b0;
  logic       reset_p;
  logic       btn_start, btn_pause, dir_req_valid, game_over_in, game_won_in;
  logic [1:0] dir_req;
  logic [6:0] tail_count;
  logic [2:0] game_state;
  logic [1:0] direction;
  logic       update_tick, logic_reset, flag_time_max;
  logic [6:0] time_left;

  int errors = 0;
  int checks = 0;

  always #5 vga_clk = ~vga_clk;

  game_sequencer #(
    .TICK_BASE(10), .TICK_STEP(2), .TICK_MIN(4), .SEC_DIV(20), .TIME_LIMIT_S(3), .TAIL_W(7)
  ) dut (
    .vga_clk       (vga_clk),
    .reset_p       (reset_p),
    .btn_start     (btn_start),
    .btn_pause     (btn_pause),
    .dir_req_valid (dir_req_valid),
    .dir_req       (dir_req),
    .game_over_in  (game_over_in),
    .game_won_in   (game_won_in),
    .tail_count    (tail_count),
    .game_state    (game_state),
    .direction     (direction),
    .update_tick   (update_tick),
    .logic_reset   (logic_reset),
    .time_left     (time_left),
    .flag_time_max (flag_time_max)
  );

  typedef struct {
    logic [6:0] tail;
    int         period;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic cyc();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic do_reset();
    reset_p = 1'b1; btn_start = 1'b0; btn_pause = 1'b0; dir_req_valid = 1'b0;
    dir_req = 2'd0; game_over_in = 1'b0; game_won_in = 1'b0;
    #2;
    cyc();
    reset_p = 1'b0;
    cyc();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " game_state"}, game_state, 0);
    check({tag, " direction"}, direction, 2);
    check({tag, " update_tick"}, update_tick, 0);
    check({tag, " logic_reset"}, logic_reset, 0);
    check({tag, " time_left"}, time_left, 3);
    check({tag, " flag_time_max"}, flag_time_max, 0);
  endtask

  task automatic start_game(input string tag);
    btn_start = 1'b1;
    @(negedge vga_clk);
    check({tag, " logic_reset pulse"}, logic_reset, 1);
    cyc();
    btn_start = 1'b0;
    #1;
    check({tag, " state ingame"}, game_state, 1);
    check({tag, " logic_reset low"}, logic_reset, 0);
  endtask

  task automatic measure_tick(output int n);
    bit found = 0;
    n = -1;
    for (int i = 1; i <= 100 && !found; i++) begin
      @(negedge vga_clk);
      if (update_tick) begin
        n = i;
        found = 1;
      end
      cyc();
    end
  endtask

  task automatic count_ticks(input int ncyc, output int t);
    t = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge vga_clk);
      if (update_tick) t++;
      cyc();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int t;

    vecs[0].tail = 7'd0;   vecs[0].period = 10;
    vecs[1].tail = 7'd1;   vecs[1].period = 8;
    vecs[2].tail = 7'd2;   vecs[2].period = 6;
    vecs[3].tail = 7'd3;   vecs[3].period = 4;
    vecs[4].tail = 7'd5;   vecs[4].period = 4;
    vecs[5].tail = 7'd127; vecs[5].period = 4;

    tail_count = 7'd0;
    do_reset();
    check_reset_values("reset");

    // tick period per tail length
    for (int i = 0; i < 6; i++) begin
      tail_count = vecs[i].tail;
      do_reset();
      start_game($sformatf("v%0d", i));
      measure_tick(n);
      check($sformatf("v%0d first tick", i), n, vecs[i].period);
      measure_tick(n);
      check($sformatf("v%0d second tick", i), n, vecs[i].period);
    end

    // direction filter
    tail_count = 7'd0;
    do_reset();
    start_game("dir");
    dir_req_valid = 1'b1; dir_req = 2'd1;
    cyc();
    dir_req = 2'd0;
    cyc();
    dir_req_valid = 1'b0;
    check("dir held before tick", direction, 2);
    measure_tick(n);
    check("dir tick spacing", n, 8);
    check("dir top committed", direction, 1);
    dir_req_valid = 1'b1; dir_req = 2'd3;
    cyc();
    dir_req_valid = 1'b0;
    measure_tick(n);
    check("dir down rejected", direction, 1);
    dir_req_valid = 1'b1; dir_req = 2'd0;
    cyc();
    dir_req_valid = 1'b0;
    measure_tick(n);
    check("dir left committed", direction, 0);

    // pause freezes counters mid-step
    do_reset();
    start_game("pause");
    repeat (4) cyc();
    btn_pause = 1'b1;
    cyc();
    btn_pause = 1'b0;
    #1;
    check("pause state", game_state, 2);
    count_ticks(50, t);
    check("pause no ticks", t, 0);
    check("pause timer frozen", time_left, 3);
    btn_pause = 1'b1;
    cyc();
    btn_pause = 1'b0;
    #1;
    check("resume state", game_state, 1);
    measure_tick(n);
    check("resume tick distance", n, 6);

    // round timer expiry
    do_reset();
    start_game("timer");
    for (int s = 2; s >= 0; s--) begin
      repeat (20) cyc();
      check($sformatf("timer time_left %0d", s), time_left, s);
    end
    check("timer flag set", flag_time_max, 1);
    check("timer still ingame", game_state, 1);
    cyc();
    check("timer won", game_state, 4);
    count_ticks(15, t);
    check("won no ticks", t, 0);
    check("won time_left held", time_left, 0);
    check("won flag held", flag_time_max, 1);
    start_game("restart");
    check("restart time_left", time_left, 3);
    check("restart flag clear", flag_time_max, 0);

    // game over on the same cycle a tick is due
    do_reset();
    start_game("over");
    repeat (9) cyc();
    game_over_in = 1'b1;
    @(negedge vga_clk);
    check("over tick suppressed", update_tick, 0);
    cyc();
    game_over_in = 1'b0;
    #1;
    check("over state", game_state, 3);
    count_ticks(5, t);
    check("over no ticks", t, 0);
    check("over state held", game_state, 3);

    start_game("won");
    cyc();
    game_won_in = 1'b1;
    cyc();
    game_won_in = 1'b0;
    #1;
    check("won_in state", game_state, 4);

    // simultaneous start and pause edges
    btn_start = 1'b1; btn_pause = 1'b1;
    @(negedge vga_clk);
    check("both in won logic_reset", logic_reset, 1);
    cyc();
    btn_start = 1'b0; btn_pause = 1'b0;
    #1;
    check("both in won start wins", game_state, 1);
    cyc();
    btn_start = 1'b1; btn_pause = 1'b1;
    cyc();
    btn_start = 1'b0; btn_pause = 1'b0;
    #1;
    check("both in ingame pause wins", game_state, 2);
    btn_start = 1'b1;
    cyc();
    btn_start = 1'b0;
    #1;
    check("start ignored in pause", game_state, 2);
    btn_pause = 1'b1;
    cyc();
    btn_pause = 1'b0;
    #1;
    check("resume after both", game_state, 1);

    // asynchronous reset mid-game
    dir_req_valid = 1'b1; dir_req = 2'd1;
    cyc();
    dir_req_valid = 1'b0;
    repeat (25) cyc();
    check("pre-reset direction", direction, 1);
    check("pre-reset time_left", time_left, 2);
    reset_p = 1'b1;
    #2;
    check_reset_values("async reset");
    cyc();
    reset_p = 1'b0;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
